// File: rtl/instr_decoder.sv
// SPI-slave (mode 0) instruction decoder: turns 16-bit frames into one-clk read/write
// strobes towards a register block and shifts read data back out on miso.
module instr_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    input  logic [7:0] data_read,
    output logic [7:0] data_write
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_ISSUE,
        DATA,
        WR_ISSUE,
        WAIT_CS
    } state_t;

    state_t     state, next_state;

    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev, cs_prev;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [3:0] bit_cnt;
    logic       rw;
    logic [4:0] cmd_sr;
    logic [7:0] tx_sr;
    logic       miso_q;

    // A deselected bus idles high, so chip select synchronizes to 1 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value.
            sclk_sync <= {sclk_sync[0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        next_state = state;
        read       = 1'b0;
        write      = 1'b0;
        if (state != IDLE && cs_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) next_state = CMD;
                end
                CMD: begin
                    if (sclk_rise && bit_cnt == 4'd7) next_state = rw ? DATA : RD_ISSUE;
                end
                RD_ISSUE: begin
                    read       = 1'b1;
                    next_state = DATA;
                end
                DATA: begin
                    if (sclk_rise && bit_cnt == 4'd15) next_state = rw ? WR_ISSUE : WAIT_CS;
                end
                WR_ISSUE: begin
                    write      = 1'b1;
                    next_state = WAIT_CS;
                end
                WAIT_CS: begin
                    next_state = WAIT_CS;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Datapath. rw is taken from the first instruction bit; the 5-bit command shifter
    // lets rw and the reserved bit fall off so only addr[5:1] remain at bit 8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 4'd0;
            rw         <= 1'b0;
            cmd_sr     <= 5'd0;
            addr       <= 6'd0;
            data_write <= 8'd0;
            tx_sr      <= 8'd0;
            miso_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= 4'd0;
                    miso_q  <= 1'b0;
                end
                CMD: begin
                    miso_q <= 1'b0;
                    if (!cs_rise && sclk_rise) begin
                        if (bit_cnt == 4'd0) rw <= mosi_s;
                        cmd_sr  <= {cmd_sr[3:0], mosi_s};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) addr <= {cmd_sr, mosi_s};
                    end
                end
                RD_ISSUE: begin
                    if (read) tx_sr <= data_read;
                end
                DATA: begin
                    if (!cs_rise) begin
                        if (sclk_rise) begin
                            if (rw) data_write <= {data_write[6:0], mosi_s};
                            // Saturate on the 16th bit; the FSM leaves DATA on that edge.
                            if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (sclk_fall && !rw) begin
                            miso_q <= tx_sr[7];
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign miso = miso_q & ~cs_s;

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  peripheral clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sclk  input  1  SPI serial clock (mode 0), asynchronous to clk; clk SHALL be at least 4x sclk.
REQ-005 cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-006 mosi  input  1  serial data in, sampled on rising sclk.
REQ-007 miso  output  1  serial data out, MSB-first, updated on falling sclk.
REQ-008 read  output  1  one-clk register read strobe to the register block.
REQ-009 write  output  1  one-clk register write strobe to the register block.
REQ-010 addr  output  6  register address, held stable from strobe until the next frame's instruction byte completes.
REQ-011 data_read  input  8  register read data, combinationally valid while read=1.
REQ-012 data_write  output  8  register write data, valid while write=1.

Function
REQ-013 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected from the last two synchronized sclk samples.
REQ-014 A frame SHALL be 16 sclk rising edges while cs_n=0: byte 0 = instruction {rw[7] (1=write), reserved[6], addr[5:0]}, byte 1 = data; both bytes MSB-first.
REQ-015 FSM states: IDLE, CMD, RD_ISSUE, DATA, WR_ISSUE, WAIT_CS.
REQ-016 IDLE->CMD on synchronized cs_n falling; the bit counter SHALL clear to 0.
REQ-017 CMD: shift mosi in on each sclk rise; after the 8th bit, latch addr=bits[5:0]; rw=1 -> DATA, rw=0 -> RD_ISSUE.
REQ-018 RD_ISSUE: assert read for exactly one clk with addr valid, load data_read into the 8-bit tx shift register in that same cycle, then go to DATA.
REQ-019 DATA: count 8 sclk rises; on a write frame shift mosi into data_write; on a read frame shift the tx register left on each sclk fall, with miso = tx[7].
REQ-020 After the 16th bit: a write frame -> WR_ISSUE; a read frame -> WAIT_CS.
REQ-021 WR_ISSUE: assert write for exactly one clk with addr and data_write stable, then go to WAIT_CS.
REQ-022 WAIT_CS: ignore further sclk edges; go to IDLE on synchronized cs_n rising.
REQ-023 cs_n rising in any state other than IDLE SHALL abort to IDLE with no strobe; a partial write SHALL never issue write.
REQ-024 read and write SHALL never be asserted in the same cycle, and each SHALL be asserted at most once per frame.
REQ-025 miso SHALL be 0 whenever cs_n (synchronized) is high and during byte 0.
REQ-026 The bit counter is 4 bits and SHALL NOT wrap within a frame; extra sclk edges after 16 bits SHALL have no effect.
REQ-027 Reserved bit 6 SHALL be ignored; an out-of-range addr SHALL still be issued (the register block returns 0x00).
REQ-028 Latency: the write strobe SHALL occur within 4 clk of the 16th synchronized sclk rise; the read strobe SHALL occur within 4 clk of the 8th rise and before the first data-phase sclk fall.

Reset
REQ-029 While rst=1: state=IDLE; read=0, write=0, addr=0x00, data_write=0x00, miso=0; counter, shift registers and synchronizers cleared (synchronized cs_n resets to 1).
REQ-030 rst asserted mid-frame SHALL abort the frame with no strobe; after release the block SHALL wait for a fresh cs_n falling edge.

Verification
REQ-031 Write frame 0x8A,0x5C -> one write pulse with addr=0x0A and data_write=0x5C; read stays 0.
REQ-032 Read frame 0x03, dummy byte, with data_read=0xA5 at addr 0x03 -> one read pulse with addr=0x03; miso shifts out 1,0,1,0,0,1,0,1 across the second byte.
REQ-033 Write 0x81,0xFF with cs_n raised after 12 bits -> no write pulse; FSM returns to IDLE; the next full frame works.
REQ-034 Frame of 20 sclk edges (write 0x8D,0x02 + 4 extra) -> exactly one write with addr=0x0D and data=0x02; extra edges ignored.
REQ-035 rst pulsed after 5 bits of a frame -> all outputs 0; a subsequent write 0x80,0x11 issues a write with addr=0x00 and data_write=0x11.
REQ-036 Back-to-back write then read frames at sclk=clk/4 -> one strobe each in order, never overlapping.
